// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                    |
// | Purpose  : Arbitrates the unified main-memory port between the I-cache   |
// |            fill path and the D-cache fill/writeback path. A dirty D-side |
// |            miss is sequenced as writeback then refill, atomically. Each  |
// |            requester gets a one-cycle done pulse with the returned line. |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            i_req/i_addr -> i_done/i_line      instruction fill          |
// |            d_req/d_addr/d_dirty/d_wb_addr/d_wb_data -> d_done/d_line     |
// |            mem_addr/mem_re/mem_we/mem_wdata, mem_rdata/mem_rdy  memory   |
// |            busy : arbiter is not idle                                    |
// | Options  : ARB_STARVE_EN - bounds consecutive data grants while an       |
// |            instruction fill waits (STARVE_MAX).                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int LINE_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_data,
  output logic              d_done,
  output logic [LINE_W-1:0] d_line,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy
);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_I_FILL = 3'd1;
  localparam logic [2:0] c_S_D_WB   = 3'd2;
  localparam logic [2:0] c_S_D_FILL = 3'd3;
  localparam logic [2:0] c_S_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [LINE_W-1:0] r_wb_data;
  logic [LINE_W-1:0] r_i_line;
  logic [LINE_W-1:0] r_d_line;
  logic              r_owner_d;   // 1: current transaction belongs to the data side
  logic              w_starve;
  logic              w_grant_i;
  logic              w_grant_d;

  // Grants are only made in IDLE. Done pulses are issued from the DONE state,
  // so a requester still holding req during its done cycle cannot be sampled
  // again until the following IDLE cycle.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == c_S_IDLE) begin
      if (i_req && (!d_req || w_starve)) begin
        w_grant_i = 1'b1;
      end else if (d_req) begin
        w_grant_d = 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_EN
  localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

  logic [c_CNT_W-1:0] r_starve_cnt;

  // Counts data grants that overtook a waiting instruction fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_i) begin
      r_starve_cnt <= '0;
    end else if ((r_state == c_S_IDLE) && !i_req) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d && i_req && (r_starve_cnt != c_CNT_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_starve = (r_starve_cnt == c_CNT_W'(STARVE_MAX));
`else
  assign w_starve = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a dirty victim is remembered by routing through D_WB.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_grant_i) begin
          w_next_state = c_S_I_FILL;
        end else if (w_grant_d) begin
          w_next_state = d_dirty ? c_S_D_WB : c_S_D_FILL;
        end
      end
      c_S_I_FILL: if (mem_rdy) w_next_state = c_S_DONE;
      c_S_D_WB:   if (mem_rdy) w_next_state = c_S_D_FILL;
      c_S_D_FILL: if (mem_rdy) w_next_state = c_S_DONE;
      c_S_DONE:   w_next_state = c_S_IDLE;
      default:    w_next_state = c_S_IDLE;
    endcase
  end

  // Request latches and returned-line registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fill_addr <= '0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_owner_d   <= 1'b0;
      r_i_line    <= '0;
      r_d_line    <= '0;
    end else begin
      if (w_grant_i) begin
        r_fill_addr <= i_addr;
        r_owner_d   <= 1'b0;
      end
      if (w_grant_d) begin
        r_fill_addr <= d_addr;
        r_wb_addr   <= d_wb_addr;
        r_wb_data   <= d_wb_data;
        r_owner_d   <= 1'b1;
      end
      if ((r_state == c_S_I_FILL) && mem_rdy) begin
        r_i_line <= mem_rdata;
      end
      if ((r_state == c_S_D_FILL) && mem_rdy) begin
        r_d_line <= mem_rdata;
      end
    end
  end

  // Output decode: memory command is a pure function of state and latches,
  // so it is stable for the whole command phase and re/we are exclusive.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (r_state)
      c_S_I_FILL, c_S_D_FILL: begin
        mem_re   = 1'b1;
        mem_addr = r_fill_addr;
      end
      c_S_D_WB: begin
        mem_we    = 1'b1;
        mem_addr  = r_wb_addr;
        mem_wdata = r_wb_data;
      end
      c_S_DONE: begin
        i_done = !r_owner_d;
        d_done = r_owner_d;
      end
      default: begin
      end
    endcase
  end

  assign busy   = (r_state != c_S_IDLE);
  assign i_line = r_i_line;
  assign d_line = r_d_line;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                |
// | Purpose  : Self-checking bench for mem_arbiter. Directed stimulus pushes |
// |            expected memory commands and done pulses (with their cycle)  |
// |            into a scoreboard; a monitor pops and compares them.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_ID = 2;
  localparam int K_DD = 3;

  typedef struct {
    int          kind;
    logic [13:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [13:0] i_addr;
  logic        i_done;
  logic [63:0] i_line;
  logic        d_req;
  logic [13:0] d_addr;
  logic        d_dirty;
  logic [13:0] d_wb_addr;
  logic [63:0] d_wb_data;
  logic        d_done;
  logic [63:0] d_line;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;
  logic        busy;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  int   cyc;
  int   lat;
  int   mcnt;

  mem_arbiter #(.ADDR_W(14), .LINE_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_line(i_line),
    .d_req(d_req), .d_addr(d_addr), .d_dirty(d_dirty),
    .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
    .d_done(d_done), .d_line(d_line),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: completes a command after 'lat' extra command cycles.
  assign mem_rdy   = (mem_re || mem_we) && (mcnt == lat);
  assign mem_rdata = (mem_addr == 14'h0010) ? 64'h1111_2222_3333_4444 :
                     {2'b00, mem_addr, 2'b01, mem_addr, 2'b10, mem_addr, 2'b11, mem_addr};

  always @(posedge clk) begin
    if (!rst_n)                mcnt <= 0;
    else if (mem_rdy)          mcnt <= 0;
    else if (mem_re || mem_we) mcnt <= mcnt + 1;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [13:0] a, input logic [63:0] d, input int c);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [13:0] a, input logic [63:0] d);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h cycle %0d, expected none",
               kind, a, d, cyc);
    end else begin
      e = sb.pop_front();
      if (kind != e.kind || a !== e.addr || d !== e.data || cyc != e.cyc) begin
        n_err++;
        $display("FAIL event: got kind %0d addr %h data %h cycle %0d, expected kind %0d addr %h data %h cycle %0d",
                 kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_re || mem_we) check("cmd_exclusive", {63'd0, mem_re && mem_we}, 64'd0);
        if (mem_rdy) observe(mem_we ? K_WR : K_RD, mem_addr, mem_we ? mem_wdata : 64'd0);
        if (i_done)  observe(K_ID, 14'h0, i_line);
        if (d_done)  observe(K_DD, 14'h0, d_line);
      end
    end
  endtask

  // Advances at least one cycle, then waits for the selected done pulse.
  task automatic wait_done(input bit is_d, input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(is_d ? d_done : i_done) && k < budget);
    if (!(is_d ? d_done : i_done)) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_%s: got no done pulse in %0d cycles, expected one", is_d ? "d" : "i", budget);
    end
  endtask

  initial begin
    int c;
    int n_d;
    bit drop_d_early;
    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
    d_dirty = 1'b0; d_wb_addr = '0; d_wb_data = '0; lat = 0;
    fork
      monitor();
    join_none

    // Reset state
    tick(3);
    check("rst_mem_re", {63'd0, mem_re}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_i_done", {63'd0, i_done}, 64'd0);
    check("rst_d_done", {63'd0, d_done}, 64'd0);
    check("rst_busy",   {63'd0, busy},   64'd0);
    check("rst_mem_addr", {50'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_i_line", i_line, 64'd0);
    check("rst_d_line", d_line, 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean instruction fill, memory latency 3
    lat = 3; i_addr = 14'h0010; i_req = 1'b1; c = cyc;
    push(K_RD, 14'h0010, 64'd0, c + 4);
    push(K_ID, 14'h0, 64'h1111_2222_3333_4444, c + 5);
    wait_done(1'b0, 20);
    i_req = 1'b0;
    tick(3);

    // Dirty data fill: writeback then refill, one done
    lat = 1; d_addr = 14'h0030; d_dirty = 1'b1; d_wb_addr = 14'h0020;
    d_wb_data = 64'hAAAA_AAAA_AAAA_AAAA; d_req = 1'b1; c = cyc;
    push(K_WR, 14'h0020, 64'hAAAA_AAAA_AAAA_AAAA, c + 2);
    push(K_RD, 14'h0030, 64'd0, c + 4);
    push(K_DD, 14'h0, 64'h0030_4030_8030_C030, c + 5);
    wait_done(1'b1, 20);
    d_req = 1'b0; d_dirty = 1'b0;
    tick(3);
    check("i_line_hold", i_line, 64'h1111_2222_3333_4444);

    // Simultaneous requests, minimum latency: data first
    lat = 0; d_addr = 14'h0040; i_addr = 14'h0050; d_req = 1'b1; i_req = 1'b1; c = cyc;
    push(K_RD, 14'h0040, 64'd0, c + 1);
    push(K_DD, 14'h0, 64'h0040_4040_8040_C040, c + 2);
    push(K_RD, 14'h0050, 64'd0, c + 4);
    push(K_ID, 14'h0, 64'h0050_4050_8050_C050, c + 5);
    wait_done(1'b1, 20);
    d_req = 1'b0;
    wait_done(1'b0, 20);
    i_req = 1'b0;
    tick(3);

    // Starvation: both held
`ifdef ARB_STARVE_EN
    n_d = 4; drop_d_early = 1'b0;
`else
    n_d = 6; drop_d_early = 1'b1;
`endif
    lat = 0; d_addr = 14'h0060; i_addr = 14'h0070; d_req = 1'b1; i_req = 1'b1; c = cyc;
    for (int k = 0; k < n_d; k++) begin
      push(K_RD, 14'h0060, 64'd0, c + 1 + 3 * k);
      push(K_DD, 14'h0, 64'h0060_4060_8060_C060, c + 2 + 3 * k);
    end
    push(K_RD, 14'h0070, 64'd0, c + 1 + 3 * n_d);
    push(K_ID, 14'h0, 64'h0070_4070_8070_C070, c + 2 + 3 * n_d);
    for (int k = 0; k < n_d; k++) begin
      wait_done(1'b1, 20);
      if (drop_d_early && k == n_d - 1) d_req = 1'b0;
    end
    wait_done(1'b0, 30);
    i_req = 1'b0; d_req = 1'b0;
    tick(3);

    // Held req through done: exactly one regrant, command 2 cycles after done
    lat = 0; i_addr = 14'h0080; i_req = 1'b1; c = cyc;
    push(K_RD, 14'h0080, 64'd0, c + 1);
    push(K_ID, 14'h0, 64'h0080_4080_8080_C080, c + 2);
    push(K_RD, 14'h0080, 64'd0, c + 4);
    push(K_ID, 14'h0, 64'h0080_4080_8080_C080, c + 5);
    wait_done(1'b0, 20);
    tick(2);
    i_req = 1'b0;
    wait_done(1'b0, 20);
    tick(4);

    // Reset during D_WB with the memory response still pending
    lat = 2; d_dirty = 1'b1; d_wb_addr = 14'h00A0; d_wb_data = 64'h0123_4567_89AB_CDEF;
    d_addr = 14'h00B0; d_req = 1'b1;
    tick(1);
    check("wb_cmd_active", {63'd0, mem_we}, 64'd1);
    tick(1);
    rst_n = 1'b0; d_req = 1'b0; d_dirty = 1'b0;
    tick(1);
    check("abort_mem_we", {63'd0, mem_we}, 64'd0);
    check("abort_busy",   {63'd0, busy},   64'd0);
    check("abort_d_done", {63'd0, d_done}, 64'd0);
    check("abort_mem_addr", {50'd0, mem_addr}, 64'd0);
    check("abort_i_line", i_line, 64'd0);
    check("abort_d_line", d_line, 64'd0);
    rst_n = 1'b1;
    tick(4);

    // Recovery fill after reset
    lat = 0; i_addr = 14'h0010; i_req = 1'b1; c = cyc;
    push(K_RD, 14'h0010, 64'd0, c + 1);
    push(K_ID, 14'h0, 64'h1111_2222_3333_4444, c + 2);
    wait_done(1'b0, 20);
    i_req = 1'b0;
    tick(4);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
